usb_data_buffer: RTL and testbench
==================================

Name: usb_data_buffer

Overview:
- 64-byte circular byte FIFO between the AHB-lite slave and the USB TX/RX engines.
- The AHB side writes or reads 1, 2 or 4 bytes per access, little-endian. The USB side pushes (RX) or pops (TX) one byte per cycle.
- Provides the occupancy count, full/empty status and sticky error flags that the AHB slave exposes as status registers.

Parameters:
- DEPTH, 64, buffer capacity in bytes; power of two.
- CNT_W, 7, occupancy width; equals log2(DEPTH)+1.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  reset; synchronous, active-high (asserted = 1).
- flush  input  1  clear buffer contents and flags.
- ahb_wr  input  1  AHB store request, 1-cycle pulse.
- ahb_rd  input  1  AHB fetch request, 1-cycle pulse.
- ahb_size  input  2  bytes per access: 0 = 1B, 1 = 2B, 2 = 4B; 3 is illegal.
- ahb_wdata  input  32  store data; byte0 = bits [7:0].
- ahb_rdata  output  32  fetch data (show-ahead, combinational).
- usb_push  input  1  RX engine stores usb_wbyte.
- usb_wbyte  input  8  RX byte.
- usb_pop  input  1  TX engine consumes usb_rbyte.
- usb_rbyte  output  8  byte at the read pointer (show-ahead).
- occupancy  output  CNT_W  bytes currently held, 0..64.
- empty  output  1  occupancy == 0.
- full  output  1  occupancy == 64.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.

Behaviour:
- Storage: 64x8 array, not reset.
- Pointers: wr_ptr and rd_ptr, 6 bits each, wrap 63 -> 0. Occupancy is a separate CNT_W-bit register.
- Reset (n_rst = 1 at a clock edge) takes priority over everything:
  - wr_ptr = rd_ptr = 0, occupancy = 0.
  - overflow = underflow = 0; empty = 1, full = 0.
  - ahb_rdata = 0 and usb_rbyte = 0 follow combinationally from occupancy = 0.
- Flush: next priority after reset, same effect as reset. All same-cycle requests are ignored and no error flag is set.
- Request size: nw = bytes of the writer, nr = bytes of the reader. AHB requests use ahb_size (1/2/4); usb_push and usb_pop count as 1.
- Writer arbitration: at most one writer per cycle.
  - ahb_wr has priority over usb_push.
  - If both are asserted, usb_push is dropped and overflow is set.
- Reader arbitration: same rule; ahb_rd beats usb_pop, the loser is dropped, underflow is set.
- ahb_size == 3 on a request: request rejected, corresponding error flag set.
- Acceptance uses pre-cycle occupancy (occ):
  - Write accepted iff occ + nw <= 64; otherwise dropped entirely (no partial write) and overflow set.
  - Read accepted iff nr <= occ; otherwise dropped (pointer unchanged) and underflow set.
  - Consequences: a read on empty with a same-cycle write is rejected; a write on full with a same-cycle read is rejected.
- Accepted write of n bytes: mem[wr_ptr + i] = ahb_wdata[8i+7:8i] for i < n; wr_ptr += n modulo 64.
- Accepted read: rd_ptr += nr modulo 64.
- Next occupancy = occ + (write accepted ? nw : 0) - (read accepted ? nr : 0). It never exceeds 64 or drops below 0.
- ahb_rdata: byte i = mem[rd_ptr + i] for i < min(ahb_size bytes, occupancy), else 0.
  - Valid in the same cycle as ahb_rd; the pointer advances at the edge ending that cycle.
  - Bytes beyond the request size are always 0.
- usb_rbyte = mem[rd_ptr] when occupancy > 0, else 0.
- empty and full are combinational decodes of the occupancy register.
- overflow and underflow stay set until reset or flush.
- Latency:
  - Written data is visible on ahb_rdata / usb_rbyte on the cycle after the write edge, provided it lies at rd_ptr.
  - occupancy updates one cycle after each request.

Test Plan:
- Reset, then AHB 4B write 0x44332211 -> occupancy = 4. Then 4 usb_pop cycles -> usb_rbyte reads 0x11, 0x22, 0x33, 0x44; empty = 1 at the end.
- 64 usb_push of bytes 0x00..0x3F -> full = 1. A further 1B ahb_wr -> rejected, overflow = 1, occupancy stays 64. A 4B ahb_rd -> ahb_rdata = 0x03020100, occupancy = 60.
- Wrap-around: fill 62 bytes, pop 60, then 4B write 0xDDCCBBAA -> bytes land at indices 62, 63, 0, 1. 4B ahb_rd after popping 2 -> 0xDDCCBBAA.
- Occupancy = 1, 2B ahb_rd -> underflow = 1, rd_ptr unchanged, ahb_rdata = 0x000000XX (one valid byte only).
- Same-cycle ahb_wr (1B) and usb_push -> only the AHB byte is stored, overflow = 1. Same-cycle ahb_wr and usb_pop at occupancy 10 -> occupancy = 10 afterwards.
- Flush or synchronous n_rst in the middle of a sequence, with ahb_wr asserted in the same cycle -> occupancy = 0, empty = 1, error flags 0, write ignored.

Source files
------------

// File: rtl/usb_data_buffer.sv
// usb_data_buffer
//   64-byte circular byte FIFO between the AHB-lite slave and the USB TX/RX
//   engines. The AHB side stores/fetches 1, 2 or 4 bytes per access
//   (little-endian). The USB side pushes (RX) or pops (TX) one byte per
//   cycle. Occupancy, full/empty and sticky overflow/underflow are exported
//   for the AHB status registers.
//
// Ports
//   clk        : system clock, rising edge
//   n_rst      : synchronous reset, active-high (asserted = 1)
//   flush      : clear contents and error flags (same effect as reset)
//   ahb_wr/rd  : AHB store/fetch request, 1-cycle pulse
//   ahb_size   : 0 = 1B, 1 = 2B, 2 = 4B, 3 = illegal (request rejected)
//   ahb_wdata  : store data, byte0 = [7:0]
//   ahb_rdata  : show-ahead fetch data, bytes past size/occupancy are 0
//   usb_push   : RX engine stores usb_wbyte
//   usb_pop    : TX engine consumes usb_rbyte
//   usb_rbyte  : byte at the read pointer, 0 when empty
//   occupancy  : bytes held, 0..DEPTH
//   empty/full : decodes of occupancy
//   overflow   : sticky, a write was rejected
//   underflow  : sticky, a read was rejected
module usb_data_buffer #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             ahb_wr,
  input  logic             ahb_rd,
  input  logic [1:0]       ahb_size,
  input  logic [31:0]      ahb_wdata,
  output logic [31:0]      ahb_rdata,
  input  logic             usb_push,
  input  logic [7:0]       usb_wbyte,
  input  logic             usb_pop,
  output logic [7:0]       usb_rbyte,
  output logic [CNT_W-1:0] occupancy,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_W = CNT_W - 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [2:0]       ahb_bytes;   // 0 flags the illegal size
  logic [2:0]       nw, nr;
  logic             wr_req, rd_req, wr_ok, rd_ok, wr_err, rd_err;
  logic [3:0]       byte_we;
  logic [PTR_W-1:0] waddr [4];
  logic [7:0]       wbyte [4];

  always_comb begin
    case (ahb_size)
      2'd0:    ahb_bytes = 3'd1;
      2'd1:    ahb_bytes = 3'd2;
      2'd2:    ahb_bytes = 3'd4;
      default: ahb_bytes = 3'd0;
    endcase
  end

  // Request arbitration, acceptance and next state.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    nw       = 3'd0;
    nr       = 3'd0;
    wr_req   = 1'b0;
    rd_req   = 1'b0;
    wr_err   = 1'b0;
    rd_err   = 1'b0;

    // AHB wins; a colliding USB request is dropped and flagged.
    if (ahb_wr) begin
      wr_req = (ahb_bytes != 3'd0);
      nw     = ahb_bytes;
      wr_err = (ahb_bytes == 3'd0) || usb_push;
    end else if (usb_push) begin
      wr_req = 1'b1;
      nw     = 3'd1;
    end

    if (ahb_rd) begin
      rd_req = (ahb_bytes != 3'd0);
      nr     = ahb_bytes;
      rd_err = (ahb_bytes == 3'd0) || usb_pop;
    end else if (usb_pop) begin
      rd_req = 1'b1;
      nr     = 3'd1;
    end

    // Both checks use the pre-cycle occupancy, so a read cannot make room
    // for a same-cycle write and a write cannot feed a same-cycle read.
    wr_ok = wr_req && ((occ_q + CNT_W'(nw)) <= CNT_W'(DEPTH));
    rd_ok = rd_req && (CNT_W'(nr) <= occ_q);
    if (wr_req && !wr_ok) wr_err = 1'b1;
    if (rd_req && !rd_ok) rd_err = 1'b1;

    wr_ptr_d = wr_ptr_q + (wr_ok ? PTR_W'(nw) : '0);
    rd_ptr_d = rd_ptr_q + (rd_ok ? PTR_W'(nr) : '0);
    occ_d    = occ_q + (wr_ok ? CNT_W'(nw) : '0) - (rd_ok ? CNT_W'(nr) : '0);
    ovf_d    = ovf_q | wr_err;
    unf_d    = unf_q | rd_err;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end

    // Storage has no reset of its own, so reset and flush must gate writes here.
    for (int i = 0; i < 4; i++) begin
      byte_we[i] = wr_ok && !flush && !n_rst && (3'(i) < nw);
      waddr[i]   = wr_ptr_q + PTR_W'(i);
      wbyte[i]   = ahb_wr ? ahb_wdata[8*i +: 8] : usb_wbyte;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // NOTE: the byte array is deliberately not reset; occupancy masks stale
  // contents, and leaving it reset-free lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_we[i]) mem_q[waddr[i]] <= wbyte[i];
    end
  end

  // Show-ahead read data, masked to the request size and the bytes held.
  always_comb begin
    ahb_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < ahb_bytes) && (CNT_W'(i) < occ_q))
        ahb_rdata[8*i +: 8] = mem_q[rd_ptr_q + PTR_W'(i)];
    end
  end

  assign usb_rbyte = (occ_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign occupancy = occ_q;
  assign empty     = (occ_q == '0);
  assign full      = (occ_q == CNT_W'(DEPTH));
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer: a table of single-cycle vectors
// (inputs, show-ahead outputs before the edge, registered state after it)
// followed by hand-written multi-cycle sequences for fill, wrap and
// arbitration corner cases.
module tb_usb_data_buffer;

  logic        clk = 1'b0;
  logic        n_rst, flush, ahb_wr, ahb_rd, usb_push, usb_pop;
  logic [1:0]  ahb_size;
  logic [31:0] ahb_wdata, ahb_rdata;
  logic [7:0]  usb_wbyte, usb_rbyte;
  logic [6:0]  occupancy;
  logic        empty, full, overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  usb_data_buffer #(.DEPTH(64), .CNT_W(7)) dut (
    .clk(clk), .n_rst(n_rst), .flush(flush),
    .ahb_wr(ahb_wr), .ahb_rd(ahb_rd), .ahb_size(ahb_size),
    .ahb_wdata(ahb_wdata), .ahb_rdata(ahb_rdata),
    .usb_push(usb_push), .usb_wbyte(usb_wbyte),
    .usb_pop(usb_pop), .usb_rbyte(usb_rbyte),
    .occupancy(occupancy), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr, rd;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        push;
    logic [7:0]  wbyte;
    logic        pop, flush, rst;
    logic [31:0] e_rdata;   // before the edge
    logic [7:0]  e_rbyte;   // before the edge
    logic [6:0]  e_occ;     // after the edge
    logic        e_empty, e_full, e_ovf, e_unf;
  } vec_t;

  function automatic vec_t mk(logic wr, logic rd, logic [1:0] size, logic [31:0] wdata,
                              logic push, logic [7:0] wbyte, logic pop, logic fl, logic rst,
                              logic [31:0] e_rdata, logic [7:0] e_rbyte, logic [6:0] e_occ,
                              logic e_empty, logic e_full, logic e_ovf, logic e_unf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.size = size; v.wdata = wdata;
    v.push = push; v.wbyte = wbyte; v.pop = pop; v.flush = fl; v.rst = rst;
    v.e_rdata = e_rdata; v.e_rbyte = e_rbyte; v.e_occ = e_occ;
    v.e_empty = e_empty; v.e_full = e_full; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  function automatic vec_t inp(logic wr, logic rd, logic [1:0] size, logic [31:0] wdata,
                               logic push, logic [7:0] wbyte, logic pop, logic fl, logic rst);
    return mk(wr, rd, size, wdata, push, wbyte, pop, fl, rst, '0, '0, '0, 0, 0, 0, 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ahb_wr = v.wr; ahb_rd = v.rd; ahb_size = v.size; ahb_wdata = v.wdata;
    usb_push = v.push; usb_wbyte = v.wbyte; usb_pop = v.pop;
    flush = v.flush; n_rst = v.rst;
  endtask

  // One clock with the given inputs, no checks.
  task automatic cyc(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check($sformatf("v%0d.rdata", idx), ahb_rdata, v.e_rdata);
    check($sformatf("v%0d.rbyte", idx), 32'(usb_rbyte), 32'(v.e_rbyte));
    @(posedge clk);
    #1;
    check($sformatf("v%0d.occ", idx),   32'(occupancy), 32'(v.e_occ));
    check($sformatf("v%0d.empty", idx), 32'(empty),     32'(v.e_empty));
    check($sformatf("v%0d.full", idx),  32'(full),      32'(v.e_full));
    check($sformatf("v%0d.ovf", idx),   32'(overflow),  32'(v.e_ovf));
    check($sformatf("v%0d.unf", idx),   32'(underflow), 32'(v.e_unf));
  endtask

  vec_t vecs[18];
  vec_t idle;

  initial begin
    idle = inp(0, 0, 2'd0, 32'h0, 0, 8'h00, 0, 0, 0);

    //           wr rd sz  wdata         pu wbyte pop fl rst  e_rdata        e_rbyte e_occ em fu ov un
    vecs[0]  = mk(1, 0, 2, 32'h44332211, 0, 8'h00, 0, 0, 0, 32'h00000000, 8'h00, 7'd4, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 32'h0,        0, 8'h00, 1, 0, 0, 32'h00000011, 8'h11, 7'd3, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0,        0, 8'h00, 1, 0, 0, 32'h00000022, 8'h22, 7'd2, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 32'h0,        0, 8'h00, 1, 0, 0, 32'h00000033, 8'h33, 7'd1, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,        0, 8'h00, 1, 0, 0, 32'h00000044, 8'h44, 7'd0, 1, 0, 0, 0);
    vecs[5]  = mk(0, 1, 0, 32'h0,        0, 8'h00, 0, 0, 0, 32'h00000000, 8'h00, 7'd0, 1, 0, 0, 1);
    vecs[6]  = mk(0, 0, 0, 32'h0,        0, 8'h00, 0, 1, 0, 32'h00000000, 8'h00, 7'd0, 1, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 32'h0,        1, 8'h5A, 0, 0, 0, 32'h00000000, 8'h00, 7'd1, 0, 0, 0, 0);
    // 2B read with one byte held: rejected, only the valid byte shows
    vecs[8]  = mk(0, 1, 1, 32'h0,        0, 8'h00, 0, 0, 0, 32'h0000005A, 8'h5A, 7'd1, 0, 0, 0, 1);
    vecs[9]  = mk(0, 1, 0, 32'h0,        0, 8'h00, 0, 0, 0, 32'h0000005A, 8'h5A, 7'd0, 1, 0, 0, 1);
    // AHB 2B write beats same-cycle push
    vecs[10] = mk(1, 0, 1, 32'h0000BEEF, 1, 8'h77, 0, 0, 0, 32'h00000000, 8'h00, 7'd2, 0, 0, 1, 1);
    vecs[11] = mk(0, 0, 2, 32'h0,        0, 8'h00, 0, 0, 0, 32'h0000BEEF, 8'hEF, 7'd2, 0, 0, 1, 1);
    // flush with a same-cycle write: write ignored, flags cleared
    vecs[12] = mk(1, 0, 2, 32'hCAFEF00D, 0, 8'h00, 0, 1, 0, 32'h0000BEEF, 8'hEF, 7'd0, 1, 0, 0, 0);
    vecs[13] = mk(0, 0, 2, 32'h0,        0, 8'h00, 0, 0, 0, 32'h00000000, 8'h00, 7'd0, 1, 0, 0, 0);
    // illegal size write
    vecs[14] = mk(1, 0, 3, 32'h12345678, 0, 8'h00, 0, 0, 0, 32'h00000000, 8'h00, 7'd0, 1, 0, 1, 0);
    vecs[15] = mk(0, 0, 0, 32'h0,        1, 8'h10, 0, 0, 0, 32'h00000000, 8'h00, 7'd1, 0, 0, 1, 0);
    // reset with a same-cycle write
    vecs[16] = mk(1, 0, 0, 32'h000000FF, 0, 8'h00, 0, 0, 1, 32'h00000010, 8'h10, 7'd0, 1, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 32'h0,        0, 8'h00, 0, 0, 0, 32'h00000000, 8'h00, 7'd0, 1, 0, 0, 0);

    // Reset state
    drive(inp(0, 0, 2'd2, 32'h0, 0, 8'h00, 0, 0, 1));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    drive(inp(0, 0, 2'd2, 32'h0, 0, 8'h00, 0, 0, 0));
    #1;
    check("rst.occ",   32'(occupancy), 32'd0);
    check("rst.empty", 32'(empty),     32'd1);
    check("rst.full",  32'(full),      32'd0);
    check("rst.ovf",   32'(overflow),  32'd0);
    check("rst.unf",   32'(underflow), 32'd0);
    check("rst.rdata", ahb_rdata,      32'h0);
    check("rst.rbyte", 32'(usb_rbyte), 32'h0);

    for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

    // Fill to full with 0x00..0x3F, reject a write, then 4B read.
    cyc(inp(0, 0, 0, 32'h0, 0, 8'h00, 0, 1, 0));
    for (int i = 0; i < 64; i++) cyc(inp(0, 0, 0, 32'h0, 1, 8'(i), 0, 0, 0));
    check("fill.occ",   32'(occupancy), 32'd64);
    check("fill.full",  32'(full),      32'd1);
    check("fill.empty", 32'(empty),     32'd0);
    check("fill.rbyte", 32'(usb_rbyte), 32'h00);
    cyc(inp(1, 0, 0, 32'h000000AA, 0, 8'h00, 0, 0, 0));
    check("full_wr.ovf", 32'(overflow),  32'd1);
    check("full_wr.occ", 32'(occupancy), 32'd64);
    @(negedge clk);
    drive(inp(0, 1, 2, 32'h0, 0, 8'h00, 0, 0, 0));
    #1;
    check("full_rd.rdata", ahb_rdata, 32'h03020100);
    @(posedge clk);
    #1;
    check("full_rd.occ",  32'(occupancy), 32'd60);
    check("full_rd.full", 32'(full),      32'd0);
    check("full_rd.unf",  32'(underflow), 32'd0);

    // Wrap-around: write straddles index 63 -> 0.
    cyc(inp(0, 0, 0, 32'h0, 0, 8'h00, 0, 1, 0));
    for (int i = 0; i < 62; i++) cyc(inp(0, 0, 0, 32'h0, 1, 8'(8'h80 + i), 0, 0, 0));
    for (int i = 0; i < 60; i++) cyc(inp(0, 0, 0, 32'h0, 0, 8'h00, 1, 0, 0));
    check("wrap.occ2",  32'(occupancy), 32'd2);
    check("wrap.rbyte", 32'(usb_rbyte), 32'hBC);
    cyc(inp(1, 0, 2, 32'hDDCCBBAA, 0, 8'h00, 0, 0, 0));
    check("wrap.occ6", 32'(occupancy), 32'd6);
    cyc(inp(0, 0, 0, 32'h0, 0, 8'h00, 1, 0, 0));
    cyc(inp(0, 0, 0, 32'h0, 0, 8'h00, 1, 0, 0));
    check("wrap.occ4",   32'(occupancy), 32'd4);
    check("wrap.rbyte2", 32'(usb_rbyte), 32'hAA);
    @(negedge clk);
    drive(inp(0, 1, 2, 32'h0, 0, 8'h00, 0, 0, 0));
    #1;
    check("wrap.rdata", ahb_rdata, 32'hDDCCBBAA);
    @(posedge clk);
    #1;
    check("wrap.occ0",  32'(occupancy), 32'd0);
    check("wrap.empty", 32'(empty),     32'd1);
    check("wrap.ovf",   32'(overflow),  32'd0);

    // Same-cycle write and pop at occupancy 10; then reader collision.
    cyc(inp(0, 0, 0, 32'h0, 0, 8'h00, 0, 1, 0));
    for (int i = 0; i < 10; i++) cyc(inp(0, 0, 0, 32'h0, 1, 8'(i), 0, 0, 0));
    cyc(inp(1, 0, 0, 32'h00000099, 0, 8'h00, 1, 0, 0));
    check("wr_pop.occ", 32'(occupancy), 32'd10);
    check("wr_pop.ovf", 32'(overflow),  32'd0);
    check("wr_pop.unf", 32'(underflow), 32'd0);
    @(negedge clk);
    drive(inp(0, 1, 0, 32'h0, 0, 8'h00, 1, 0, 0));
    #1;
    check("rd_pop.rdata", ahb_rdata, 32'h00000001);
    @(posedge clk);
    #1;
    check("rd_pop.occ",   32'(occupancy), 32'd9);
    check("rd_pop.unf",   32'(underflow), 32'd1);
    check("rd_pop.rbyte", 32'(usb_rbyte), 32'h02);
    cyc(idle);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
